aes_encrypt_iter: RTL and testbench



---
 rtl/aes_pkg.sv | 66 ++++++
 rtl/aes_encrypt_iter_if.sv | 23 ++
 rtl/aes_round.sv | 32 +++
 rtl/aes_encrypt_iter.sv | 153 +++++++++++++++
 tb/tb_aes_encrypt_iter.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: S-box, GF(2^8) arithmetic, key-size derivations and FSM state type.
package aes_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sub_byte(input logic [7:0] b);
      return SBOX[b];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sub_byte(w[31:24]), sub_byte(w[23:16]), sub_byte(w[15:8]), sub_byte(w[7:0])};
   endfunction

   function automatic logic [31:0] rot_word(input logic [31:0] w);
      return {w[23:0], w[31:24]};
   endfunction

   // Multiply by x modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int unsigned i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic int unsigned nk_of(input int unsigned key_width);
      return key_width / 32;
   endfunction

   function automatic int unsigned nr_of(input int unsigned key_width);
      return key_width / 32 + 6;
   endfunction

endpackage

// File: rtl/aes_encrypt_iter_if.sv
// Block/key input and ciphertext output handshake bundle for aes_encrypt_iter.
interface aes_encrypt_iter_if #(
   parameter int unsigned KEY_WIDTH = 128
);
   logic                 in_valid;
   logic                 in_ready;
   logic [127:0]         i_block;
   logic [KEY_WIDTH-1:0] key;
   logic                 out_valid;
   logic                 out_ready;
   logic [127:0]         o_block;
   logic                 busy;

   modport master (
      output in_valid, i_block, key, out_ready,
      input  in_ready, out_valid, o_block, busy
   );

   modport slave (
      input  in_valid, i_block, key, out_ready,
      output in_ready, out_valid, o_block, busy
   );
endinterface

// File: rtl/aes_round.sv
// One combinational AES round: SubBytes, ShiftRows, MixColumns (bypassed on the last round), AddRoundKey.
module aes_round
   import aes_pkg::*;
(
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   input  logic         last,
   output logic [127:0] state_out
);

   logic [7:0] sb [16];
   logic [7:0] sr [16];
   logic [7:0] mc [16];

   // Byte n sits at bits [127-8n -: 8]; n = row + 4*column.
   always_comb begin
      for (int unsigned n = 0; n < 16; n++) sb[n] = sub_byte(state_in[127-8*n -: 8]);
      for (int unsigned c = 0; c < 4; c++)
         for (int unsigned r = 0; r < 4; r++)
            sr[4*c+r] = sb[4*((c+r)%4)+r];
      for (int unsigned c = 0; c < 4; c++) begin
         mc[4*c]   = xtime(sr[4*c]) ^ xtime(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+1] = sr[4*c] ^ xtime(sr[4*c+1]) ^ xtime(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
         mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xtime(sr[4*c+2]) ^ xtime(sr[4*c+3]) ^ sr[4*c+3];
         mc[4*c+3] = xtime(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xtime(sr[4*c+3]);
      end
      state_out = '0;
      for (int unsigned n = 0; n < 16; n++)
         state_out[127-8*n -: 8] = (last ? sr[n] : mc[n]) ^ round_key[127-8*n -: 8];
   end

endmodule

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128/192/256 encryptor: one round per clock, round keys expanded on the fly.
// AES_ZEROIZE_EN: clears state, key window, rcon and o_block after every output handshake.
module aes_encrypt_iter
   import aes_pkg::*;
#(
   parameter int unsigned KEY_WIDTH = 128
) (
   input logic               clk,
   input logic               rst_n,
   aes_encrypt_iter_if.slave bus
);

   localparam int unsigned NK       = nk_of(KEY_WIDTH);
   localparam int unsigned NR       = nr_of(KEY_WIDTH);
   localparam logic [3:0]  LAST_RND = 4'(NR);

   state_t               state_q, state_d;
   logic [127:0]         blk_q;
   logic [KEY_WIDTH-1:0] win_q, win_next;
   logic [3:0]           rnd_q;
   logic [7:0]           rcon_q, rcon_next;
   logic [127:0]         o_block_q;
   logic                 out_valid_q, busy_q;
   logic                 load, step, finish, ready, last_rnd, rcon_hit;
   logic [127:0]         round_key, round_out;
   logic [5:0]           phase;
   logic [31:0]          ext [NK+4];
   logic [31:0]          tmp;

   // Window holds schedule words w[4r-4 .. 4r+Nk-5] entering round r; each round
   // shifts it by four words, so the new first four words are round key r.
   // phase is the schedule index (mod Nk) of the first word appended this round.
   assign phase    = {rnd_q - 4'd1, 2'b00} % 6'(NK);
   assign last_rnd = (rnd_q == LAST_RND);

   always_comb begin
      for (int unsigned i = 0; i < NK + 4; i++) ext[i] = '0;
      for (int unsigned i = 0; i < NK; i++) ext[i] = win_q[KEY_WIDTH-1-32*i -: 32];
      tmp      = '0;
      rcon_hit = 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
         tmp = ext[NK+k-1];
         if ((32'(phase) + k) % NK == 0) begin
            tmp      = sub_word(rot_word(tmp)) ^ {rcon_q, 24'h000000};
            rcon_hit = 1'b1;
         end else if (NK == 8 && (32'(phase) + k) % NK == 4) begin
            tmp = sub_word(tmp);
         end
         ext[NK+k] = ext[k] ^ tmp;
      end
      win_next = '0;
      for (int unsigned i = 0; i < NK; i++) win_next[KEY_WIDTH-1-32*i -: 32] = ext[i+4];
      round_key = {ext[4], ext[5], ext[6], ext[7]};
      rcon_next = rcon_hit ? xtime(rcon_q) : rcon_q;
   end

   aes_round u_round (
      .state_in  (blk_q),
      .round_key (round_key),
      .last      (last_rnd),
      .state_out (round_out)
   );

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
      ready   = 1'b0;
      case (state_q)
         IDLE: begin
            ready = 1'b1;
            if (bus.in_valid) begin
               load    = 1'b1;
               state_d = ROUND;
            end
         end
         ROUND: begin
            step = 1'b1;
            if (last_rnd) begin
               finish  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            ready = bus.out_ready;
            if (bus.out_ready) begin
               if (bus.in_valid) begin
                  load    = 1'b1;
                  state_d = ROUND;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= (state_d == DONE);
         busy_q      <= (state_d == ROUND);
      end
   end

`ifdef AES_ZEROIZE_EN
   logic clear;
   assign clear = (state_q == DONE) && bus.out_ready;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_q     <= '0;
         win_q     <= '0;
         rnd_q     <= '0;
         rcon_q    <= '0;
         o_block_q <= '0;
      end else begin
         if (load) begin
            blk_q  <= bus.i_block ^ bus.key[KEY_WIDTH-1 -: 128];
            win_q  <= bus.key;
            rnd_q  <= 4'd1;
            rcon_q <= 8'h01;
         end else if (step) begin
            blk_q  <= round_out;
            win_q  <= win_next;
            rcon_q <= rcon_next;
            rnd_q  <= rnd_q + 4'd1;
            if (finish) o_block_q <= round_out;
         end
`ifdef AES_ZEROIZE_EN
         else if (clear) begin
            blk_q  <= '0;
            win_q  <= '0;
            rcon_q <= '0;
         end
         if (clear) o_block_q <= '0;
`endif
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = out_valid_q;
   assign bus.o_block   = o_block_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Directed bench for aes_encrypt_iter using FIPS-197 vectors on 128/192/256-bit instances.
module tb_aes_encrypt_iter;

   localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K128 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [191:0] K192 = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
   localparam logic [255:0] K256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] C128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] C256 = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] PB   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] KB   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CB   = 128'h3925841d02dc09fbdc118597196a0b32;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   lat;
   int   bad;
   logic busy1;

   always #5 clk = ~clk;

   aes_encrypt_iter_if #(.KEY_WIDTH(128)) bus128 ();
   aes_encrypt_iter_if #(.KEY_WIDTH(192)) bus192 ();
   aes_encrypt_iter_if #(.KEY_WIDTH(256)) bus256 ();

   aes_encrypt_iter #(.KEY_WIDTH(128)) u128 (.clk(clk), .rst_n(rst_n), .bus(bus128));
   aes_encrypt_iter #(.KEY_WIDTH(192)) u192 (.clk(clk), .rst_n(rst_n), .bus(bus192));
   aes_encrypt_iter #(.KEY_WIDTH(256)) u256 (.clk(clk), .rst_n(rst_n), .bus(bus256));

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic ov(input int w);
      case (w)
         192:     return bus192.out_valid;
         256:     return bus256.out_valid;
         default: return bus128.out_valid;
      endcase
   endfunction

   function automatic logic [127:0] ob(input int w);
      case (w)
         192:     return bus192.o_block;
         256:     return bus256.o_block;
         default: return bus128.o_block;
      endcase
   endfunction

   function automatic logic bsy(input int w);
      case (w)
         192:     return bus192.busy;
         256:     return bus256.busy;
         default: return bus128.busy;
      endcase
   endfunction

   // Caller has in_valid raised on an idle instance; the next edge is the accept edge.
   task automatic run_lat(input int w, output int n, output logic b1);
      @(posedge clk); #1;
      bus128.in_valid = 1'b0;
      bus192.in_valid = 1'b0;
      bus256.in_valid = 1'b0;
      b1 = bsy(w);
      n  = 0;
      while (!ov(w) && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   initial begin
      rst_n = 1'b0;
      bus128.in_valid = 1'b0; bus128.i_block = '0; bus128.key = '0; bus128.out_ready = 1'b0;
      bus192.in_valid = 1'b0; bus192.i_block = '0; bus192.key = '0; bus192.out_ready = 1'b1;
      bus256.in_valid = 1'b0; bus256.i_block = '0; bus256.key = '0; bus256.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready",  128'(bus128.in_ready),  128'd1);
      check("rst_out_valid", 128'(bus128.out_valid), 128'd0);
      check("rst_busy",      128'(bus128.busy),      128'd0);
      check("rst_o_block",   bus128.o_block,         128'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // AES-128 with the sink stalled
      bus128.i_block = PT; bus128.key = K128; bus128.in_valid = 1'b1;
      run_lat(128, lat, busy1);
      check("aes128_busy",    128'(busy1), 128'd1);
      check("aes128_latency", 128'(lat),   128'd10);
      check("aes128_cipher",  ob(128),     C128);

      bad = 0;
      repeat (20) begin
         @(posedge clk); #1;
         if (bus128.out_valid !== 1'b1 || bus128.o_block !== C128 || bus128.in_ready !== 1'b0) bad++;
      end
      check("hold_unstable_cycles", 128'(bad), 128'd0);
      check("hold_in_ready", 128'(bus128.in_ready), 128'd0);

      // Output and input handshake on the same edge
      bus128.i_block = PB; bus128.key = KB; bus128.in_valid = 1'b1; bus128.out_ready = 1'b1;
      #1;
      check("b2b_in_ready", 128'(bus128.in_ready), 128'd1);
      run_lat(128, lat, busy1);
      check("b2b_busy",    128'(busy1), 128'd1);
      check("b2b_latency", 128'(lat),   128'd10);
      check("b2b_cipher",  ob(128),     CB);
      @(posedge clk); #1;
      check("post_out_valid", 128'(bus128.out_valid), 128'd0);
      check("post_in_ready",  128'(bus128.in_ready),  128'd1);
`ifdef AES_ZEROIZE_EN
      check("post_o_block_zeroized", bus128.o_block, 128'd0);
`else
      check("post_o_block_retained", bus128.o_block, CB);
`endif

      bus192.i_block = PT; bus192.key = K192; bus192.in_valid = 1'b1;
      run_lat(192, lat, busy1);
      check("aes192_latency", 128'(lat), 128'd12);
      check("aes192_cipher",  ob(192),   C192);

      bus256.i_block = PT; bus256.key = K256; bus256.in_valid = 1'b1;
      run_lat(256, lat, busy1);
      check("aes256_latency", 128'(lat), 128'd14);
      check("aes256_cipher",  ob(256),   C256);

      // Reset in the middle of round 5
      @(posedge clk); #1;
      bus128.i_block = PT; bus128.key = K128; bus128.in_valid = 1'b1;
      @(posedge clk); #1;
      bus128.in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      check("pre_reset_busy", 128'(bus128.busy), 128'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", 128'(bus128.out_valid), 128'd0);
      check("midrst_busy",      128'(bus128.busy),      128'd0);
      check("midrst_in_ready",  128'(bus128.in_ready),  128'd1);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      bus128.i_block = PT; bus128.key = K128; bus128.in_valid = 1'b1;
      run_lat(128, lat, busy1);
      check("after_rst_latency", 128'(lat), 128'd10);
      check("after_rst_cipher",  ob(128),   C128);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
